gsm_dial_seq: RTL and testbench

Command sequencer between the UART command decoder and the UART transmitter feeding the GSM module. It takes the decoder's dial/hang-up pulses and 11-digit ASCII number and serialises the matching AT command ("ATD<number>;\r" or "ATH\r") byte by byte over a busy/enable handshake. It arbitrates pending dial and hang-up requests, tracks call state, and enforces a guard gap between commands.

---
 rtl/gsm_dial_seq.sv | 171 +++++++++++++++++
 tb/tb_gsm_dial_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gsm_dial_seq.sv
// AT command sequencer: turns dial/hang-up pulses into "ATD<number>;\r" / "ATH\r"
// byte streams over a tx_en/tx_busy handshake, with request latching and a guard gap.
module gsm_dial_seq #(
   parameter int GUARD_CYC = 25_000_000,
   parameter int ACK_WAIT  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dial_req,
   input  logic        hang_req,
   input  logic [87:0] number,
   input  logic        tx_busy,
   output logic [7:0]  tx_data,
   output logic        tx_en,
   output logic        busy,
   output logic        call_active,
   output logic        cmd_done
);

   localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
   localparam int AW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

   typedef enum logic [2:0] {IDLE, SEND, WAIT_B, WAIT_D, GUARD} state_t;

   state_t         state_q, state_d;
   logic           dial_pend_q, dial_pend_d;
   logic           hang_pend_q, hang_pend_d;
   logic           is_dial_q, is_dial_d;
   logic [87:0]    shadow_q, shadow_d;
   logic [3:0]     idx_q, idx_d;
   logic [AW-1:0]  ack_q, ack_d;
   logic [GW-1:0]  guard_q, guard_d;
   logic [7:0]     tx_data_d;
   logic           tx_en_d, busy_d, call_active_d, cmd_done_d;
   logic [7:0]     frame_byte;
   logic [3:0]     last_idx;
   logic [10:0][7:0] digits;

   // digits[10] is the first dialled digit
   assign digits   = shadow_q;
   assign last_idx = is_dial_q ? 4'd15 : 4'd3;

   always_comb begin
      frame_byte = 8'h00;
      if (is_dial_q) begin
         case (idx_q)
            4'd0:    frame_byte = 8'h41;
            4'd1:    frame_byte = 8'h54;
            4'd2:    frame_byte = 8'h44;
            4'd14:   frame_byte = 8'h3B;
            4'd15:   frame_byte = 8'h0D;
            default: frame_byte = digits[4'd13 - idx_q];
         endcase
      end else begin
         case (idx_q)
            4'd0:    frame_byte = 8'h41;
            4'd1:    frame_byte = 8'h54;
            4'd2:    frame_byte = 8'h48;
            4'd3:    frame_byte = 8'h0D;
            default: frame_byte = 8'h00;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      dial_pend_d   = dial_pend_q;
      hang_pend_d   = hang_pend_q;
      is_dial_d     = is_dial_q;
      shadow_d      = shadow_q;
      idx_d         = idx_q;
      ack_d         = ack_q;
      guard_d       = guard_q;
      tx_data_d     = tx_data;
      tx_en_d       = 1'b0;
      busy_d        = busy;
      call_active_d = call_active;
      cmd_done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (hang_pend_q) begin
               hang_pend_d = 1'b0;
               is_dial_d   = 1'b0;
               idx_d       = 4'd0;
               busy_d      = 1'b1;
               state_d     = SEND;
            end else if (dial_pend_q) begin
               dial_pend_d = 1'b0;
               is_dial_d   = 1'b1;
               shadow_d    = number;
               idx_d       = 4'd0;
               busy_d      = 1'b1;
               state_d     = SEND;
            end
         end
         SEND: begin
            if (!tx_busy) begin
               tx_data_d = frame_byte;
               tx_en_d   = 1'b1;
               ack_d     = '0;
               state_d   = WAIT_B;
            end
         end
         WAIT_B: begin
            // a transmitter that never acknowledges must not stall the frame
            if (tx_busy || ack_q == AW'(ACK_WAIT - 1)) state_d = WAIT_D;
            else                                       ack_d   = ack_q + 1'b1;
         end
         WAIT_D: begin
            if (!tx_busy) begin
               if (idx_q == last_idx) begin
                  cmd_done_d    = 1'b1;
                  call_active_d = is_dial_q;
                  guard_d       = '0;
                  state_d       = GUARD;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = SEND;
               end
            end
         end
         GUARD: begin
            if (guard_q == GW'(GUARD_CYC - 1)) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               guard_d = guard_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // new requests win over the clear of a latch taken this cycle
      if (hang_req) hang_pend_d = 1'b1;
      if (dial_req && !(call_active && !hang_pend_q && !hang_req)) dial_pend_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         dial_pend_q <= 1'b0;
         hang_pend_q <= 1'b0;
         is_dial_q   <= 1'b0;
         shadow_q    <= '0;
         idx_q       <= '0;
         ack_q       <= '0;
         guard_q     <= '0;
         tx_data     <= 8'h00;
         tx_en       <= 1'b0;
         busy        <= 1'b0;
         call_active <= 1'b0;
         cmd_done    <= 1'b0;
      end else begin
         state_q     <= state_d;
         dial_pend_q <= dial_pend_d;
         hang_pend_q <= hang_pend_d;
         is_dial_q   <= is_dial_d;
         shadow_q    <= shadow_d;
         idx_q       <= idx_d;
         ack_q       <= ack_d;
         guard_q     <= guard_d;
         tx_data     <= tx_data_d;
         tx_en       <= tx_en_d;
         busy        <= busy_d;
         call_active <= call_active_d;
         cmd_done    <= cmd_done_d;
      end
   end

endmodule

// File: tb/tb_gsm_dial_seq.sv
// Scoreboard bench for gsm_dial_seq: expected bytes are queued per request and
// popped as tx_en pulses appear; a small UART model drives tx_busy.
module tb_gsm_dial_seq;

   localparam int GUARD = 8;
   localparam int ACKW  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        dial_req = 1'b0;
   logic        hang_req = 1'b0;
   logic [87:0] number = 88'h0;
   logic        tx_busy;
   logic [7:0]  tx_data;
   logic        tx_en, busy, call_active, cmd_done;

   gsm_dial_seq #(.GUARD_CYC(GUARD), .ACK_WAIT(ACKW)) dut (
      .clk(clk), .rst_n(rst_n), .dial_req(dial_req), .hang_req(hang_req),
      .number(number), .tx_busy(tx_busy), .tx_data(tx_data), .tx_en(tx_en),
      .busy(busy), .call_active(call_active), .cmd_done(cmd_done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];

   // UART model: busy for 10 clocks after each accepted tx_en
   bit uart_en = 1'b1;
   int uart_cnt = 0;
   assign tx_busy = (uart_cnt != 0);
   always @(negedge clk) begin
      if (tx_en && uart_en) uart_cnt = 10;
      else if (uart_cnt > 0) uart_cnt = uart_cnt - 1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   int tx_cnt = 0, prev_tx = 0, tx_period = 0;
   int done_cnt = 0, done_cyc = 0, fall_cyc = 0, gap = 0;
   bit gap_pend = 0, prev_busy = 0, done_ca = 0;
   logic [7:0] e;

   always @(negedge clk) begin
      if (tx_en) begin
         tx_cnt++;
         tx_period = cyc - prev_tx;
         prev_tx = cyc;
         if (gap_pend) begin gap = cyc - done_cyc; gap_pend = 0; end
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_tx_en: got data %h, required no tx_en", tx_data);
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               fails++;
               $display("FAIL tx_byte: got %h, required %h", tx_data, e);
            end
         end
      end
      if (cmd_done) begin
         done_cnt++; done_cyc = cyc; gap_pend = 1; done_ca = call_active;
      end
      if (prev_busy && !busy) fall_cyc = cyc;
      prev_busy = busy;
   end

   task automatic push_dial(input logic [87:0] num);
      exp_q.push_back(8'h41); exp_q.push_back(8'h54); exp_q.push_back(8'h44);
      for (int k = 0; k < 11; k++) exp_q.push_back(num[87-8*k -: 8]);
      exp_q.push_back(8'h3B); exp_q.push_back(8'h0D);
   endtask

   task automatic push_hang();
      exp_q.push_back(8'h41); exp_q.push_back(8'h54);
      exp_q.push_back(8'h48); exp_q.push_back(8'h0D);
   endtask

   task automatic pulse(input bit d, input bit h);
      @(negedge clk); dial_req = d; hang_req = h;
      @(negedge clk); dial_req = 0; hang_req = 0;
   endtask

   task automatic wait_done(input int target, input int maxc, input string name);
      int n = 0;
      while (!(done_cnt >= target && !busy && exp_q.size() == 0) && n < maxc) begin
         @(negedge clk); n++;
      end
      @(negedge clk);
      tests++;
      if (n >= maxc) begin
         fails++;
         $display("FAIL %s_timeout: done=%0d queue=%0d, required done=%0d queue=0",
                  name, done_cnt, exp_q.size(), target);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if ({tx_en, tx_data, busy, call_active, cmd_done} !== 12'h0) begin
         fails++;
         $display("FAIL reset_outputs: got %h, required 000",
                  {tx_en, tx_data, busy, call_active, cmd_done});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_dial();
      int d0 = done_cnt;
      number = "18237299475";
      push_dial(number);
      @(negedge clk); dial_req = 1;
      @(negedge clk); dial_req = 0;             // edge E passed
      tests++;
      if (busy !== 1'b0 || tx_en !== 1'b0) begin
         fails++; $display("FAIL lat_E: busy=%b tx_en=%b, required 0 0", busy, tx_en);
      end
      @(negedge clk);                           // E+1
      tests++;
      if (busy !== 1'b1 || tx_en !== 1'b0) begin
         fails++; $display("FAIL lat_E1: busy=%b tx_en=%b, required 1 0", busy, tx_en);
      end
      @(negedge clk);                           // E+2
      tests++;
      if (tx_en !== 1'b1) begin
         fails++; $display("FAIL lat_E2: tx_en=%b, required 1", tx_en);
      end
      wait_done(d0 + 1, 600, "dial");
      tests++;
      if (done_cnt != d0 + 1 || done_ca !== 1'b1) begin
         fails++;
         $display("FAIL dial_done: done=%0d ca=%b, required %0d 1", done_cnt, done_ca, d0 + 1);
      end
      tests++;
      if (fall_cyc - done_cyc != GUARD) begin
         fails++;
         $display("FAIL busy_guard: got %0d, required %0d", fall_cyc - done_cyc, GUARD);
      end
   endtask

   task automatic test_hangup();
      int d0 = done_cnt;
      push_hang();
      pulse(0, 1);
      wait_done(d0 + 1, 200, "hang");
      tests++;
      if (done_ca !== 1'b0 || call_active !== 1'b0) begin
         fails++;
         $display("FAIL hang_call_active: at_done=%b now=%b, required 0 0", done_ca, call_active);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (busy !== 1'b0) begin
         fails++; $display("FAIL hang_idle: busy=%b, required 0", busy);
      end
   endtask

   task automatic test_simultaneous();
      int d0 = done_cnt;
      number = "98765432101";
      push_hang();
      push_dial(number);
      pulse(1, 1);
      wait_done(d0 + 2, 900, "simul");
      tests++;
      if (done_cnt != d0 + 2 || call_active !== 1'b1) begin
         fails++;
         $display("FAIL simul_done: done=%0d ca=%b, required %0d 1", done_cnt, call_active, d0 + 2);
      end
      tests++;
      if (gap != GUARD + 2) begin
         fails++; $display("FAIL simul_gap: got %0d, required %0d", gap, GUARD + 2);
      end
   endtask

   task automatic test_dial_ignored();
      bit bad = 0;
      pulse(1, 0);
      repeat (20) begin
         @(negedge clk);
         if (tx_en !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      tests++;
      if (bad) begin
         fails++; $display("FAIL dial_ignored: activity seen=1, required 0");
      end
   endtask

   task automatic test_number_change();
      int d0, n;
      test_hangup();
      d0 = done_cnt;
      number = "31415926535";
      push_dial(number);
      n = tx_cnt;
      pulse(1, 0);
      for (int i = 0; i < 300 && tx_cnt < n + 5; i++) @(negedge clk);
      number = "00000000000";
      wait_done(d0 + 1, 600, "numchg");
      tests++;
      if (call_active !== 1'b1) begin
         fails++; $display("FAIL numchg_ca: got %b, required 1", call_active);
      end
   endtask

   task automatic test_no_busy();
      int d0;
      test_hangup();
      d0 = done_cnt;
      uart_en = 0;
      number = "27182818284";
      push_dial(number);
      pulse(1, 0);
      wait_done(d0 + 1, 600, "nobusy");
      tests++;
      if (tx_period != ACKW + 2) begin
         fails++; $display("FAIL nobusy_period: got %0d, required %0d", tx_period, ACKW + 2);
      end
      uart_en = 1;
   endtask

   task automatic test_reset_mid();
      int n;
      bit bad = 0;
      test_hangup();
      number = "11122233344";
      push_dial(number);
      n = tx_cnt;
      pulse(1, 0);
      for (int i = 0; i < 300 && tx_cnt < n + 7; i++) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({tx_en, tx_data, busy, call_active, cmd_done} !== 12'h0) begin
         fails++;
         $display("FAIL reset_async: got %h, required 000",
                  {tx_en, tx_data, busy, call_active, cmd_done});
      end
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (tx_en !== 1'b0 || busy !== 1'b0) bad = 1;
      end
      tests++;
      if (bad) begin
         fails++; $display("FAIL reset_no_replay: activity seen=1, required 0");
      end
   endtask

   initial begin
      test_reset();
      test_dial();
      test_hangup();
      test_simultaneous();
      test_dial_ignored();
      test_number_change();
      test_no_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
